display_buffer_arbiter: RTL
===========================

# display_buffer_arbiter

Owns the single write port of the character display buffer and shares it between CPU display writes (from the display instruction dispatcher) and an internal screen-clear engine. CPU writes pass through a small ordered FIFO. A clear request sweeps every screen position with the blank character, one per cycle. CPU writes that arrive during a sweep are held and written after it. Sits between the dispatcher and the display buffer RAM.

## Interface
- POSITIONS, 2400, number of screen cells (80x30); valid positions 0..POSITIONS-1
- FIFO_DEPTH, 8, CPU write FIFO entries; power of two, ≥2
- BLANK_CODE, 7'h20, character written by a clear

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_write_enable  in  1  CPU write strobe, one write per cycle high
- cpu_position  in  12  CPU write position
- cpu_char_code  in  7  CPU write character
- clear_request  in  1  single-cycle pulse: start (or restart) a full-screen clear
- busy  out  1  high while clear sweep in progress
- overflow  out  1  sticky: a CPU write was dropped because the FIFO was full
- buffer_write_enable  out  1  display buffer write strobe
- buffer_position  out  12  display buffer write address
- buffer_char_code  out  7  display buffer write data

## Operation
- Reset values: all outputs 0; state IDLE; FIFO empty; clear counter 0.
- States:
  - IDLE: pops the FIFO head each cycle the FIFO is non-empty and drives it to the outputs; otherwise buffer_write_enable=0 and position/char=0.
  - CLEAR: issues one blank write per cycle at position counter, with counter 0..POSITIONS-1. No FIFO pops.
- Transitions:
  - IDLE->CLEAR on clear_request.
  - CLEAR->IDLE on the edge that issues position POSITIONS-1.
  - clear_request while in CLEAR restarts the counter at 0.
- Flush rule: on an edge where clear_request is sampled, every FIFO entry enqueued before that edge is discarded, because the clear overwrites it. A CPU write sampled on the same edge is kept and lands after the clear.
- Enqueue:
  - Any cycle with cpu_write_enable=1 and cpu_position<POSITIONS.
  - cpu_position≥POSITIONS is silently dropped; the FIFO is unchanged.
- Full FIFO:
  - A push with a simultaneous pop is accepted.
  - A push without a pop is dropped and overflow←1.
  - overflow clears only on reset.
- Ordering: CPU writes reach the buffer in acceptance order. No clear blank ever follows a CPU write accepted at or after that clear's request edge.
- Counter width: 12 bits; counter compares against POSITIONS-1 and never wraps.
- Reset mid-clear: the sweep aborts and the FIFO is emptied. The buffer is left partially cleared, which is not repaired.

## Timing
- All outputs are registered.
- CPU write latency:
  - Write sampled at edge k, IDLE, FIFO empty: enqueued at edge k and output at edge k+1.
  - buffer_write_enable is high for exactly one cycle after edge k+1, i.e. 2-cycle latency.
  - Back-to-back CPU writes in IDLE produce back-to-back output writes at the same latency.
- Clear:
  - clear_request sampled at edge k: busy=1 from edge k.
  - Edges k+1..k+POSITIONS output positions 0..POSITIONS-1 with BLANK_CODE.
  - busy=0 and state IDLE after edge k+POSITIONS.
  - The first held CPU write is output at edge k+POSITIONS+1.
- Capacity: during a sweep, FIFO_DEPTH CPU writes are held; the next one sets overflow.

## Structure
- Shared package display_pkg:
  - POSITION_W=12, CHAR_W=7
  - SCREEN_POSITIONS=2400, BLANK_CODE=7'h20
  - State encoding (IDLE, CLEAR)
  - FIFO entry layout {position, char_code}
- One sub-module, display_write_fifo:
  - Synchronous FIFO, 19-bit entries, parameter FIFO_DEPTH.
  - push, pop, and a flush that takes priority over pop but keeps a same-cycle push.
  - Outputs full, empty and head data.
- Arbiter top: FSM, clear counter, output registers, overflow flag.

## Test plan
- After reset, one write pos 12'h005 char 7'h41: exactly one cycle with enable=1, pos 5, char 41, two edges later; outputs 0 otherwise.
- Three consecutive writes (pos 1,2,3) in IDLE: three consecutive output cycles in order, starting at latency 2.
- clear_request pulse: 2400 consecutive writes, pos 0..2399, char 7'h20; busy high exactly 2400 cycles; then idle outputs.
- During a clear, 9 writes (pos 100..108):
  - overflow=1 after the 9th.
  - After the last blank, pos 100..107 are written in order; 108 never appears.
- Flush and same-edge ordering:
  - Write pos 50 is enqueued, then clear_request arrives in the same cycle as write pos 10.
  - Pos 50 never appears; pos 10 is written once, after blank 2399.
  - A restart request mid-sweep re-begins at 0.
- Reset asserted when the sweep is at pos 100: next cycle all outputs 0, busy 0, overflow 0; a subsequent write has latency 2. Write pos 2400 is dropped with no output and no overflow.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display buffer write path.
// The FIFO entry layout and the arbiter state encoding live here so the
// arbiter, its FIFO and the bus interface all agree on field widths.
package display_pkg;

   localparam int POSITION_W         = 12;
   localparam int CHAR_W             = 7;
   localparam int SCREEN_POSITIONS   = 2400;
   localparam int DEFAULT_FIFO_DEPTH = 8;
   localparam int ENTRY_W            = POSITION_W + CHAR_W;

   localparam logic [CHAR_W-1:0] BLANK_CODE = 7'h20;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [POSITION_W-1:0] position;
      logic [CHAR_W-1:0]     charCode;
   } fifo_entry_t;

   function automatic fifo_entry_t makeEntry(input logic [POSITION_W-1:0] position,
                                             input logic [CHAR_W-1:0]     charCode);
      fifo_entry_t entry;
      entry.position = position;
      entry.charCode = charCode;
      return entry;
   endfunction

endpackage

// File: rtl/display_buffer_arbiter_if.sv
// Bus between the display instruction dispatcher (master side) and the
// display buffer arbiter (slave side). Carries the CPU write strobe, the
// clear request, status flags and the display buffer write port.
interface display_buffer_arbiter_if;
   import display_pkg::*;

   logic                  cpu_write_enable;
   logic [POSITION_W-1:0] cpu_position;
   logic [CHAR_W-1:0]     cpu_char_code;
   logic                  clear_request;
   logic                  busy;
   logic                  overflow;
   logic                  buffer_write_enable;
   logic [POSITION_W-1:0] buffer_position;
   logic [CHAR_W-1:0]     buffer_char_code;

   modport master (
      output cpu_write_enable, cpu_position, cpu_char_code, clear_request,
      input  busy, overflow, buffer_write_enable, buffer_position, buffer_char_code
   );

   modport slave (
      input  cpu_write_enable, cpu_position, cpu_char_code, clear_request,
      output busy, overflow, buffer_write_enable, buffer_position, buffer_char_code
   );

endinterface

// File: rtl/display_write_fifo.sv
// Small ordered FIFO that holds CPU display writes until the arbiter can
// issue them. A flush discards everything already stored but still keeps a
// push arriving on the same edge, so a write racing a clear survives it.
module display_write_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int ENTRY_W    = 19
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push_i,
   input  logic [ENTRY_W-1:0] pushData_i,
   input  logic               pop_i,
   input  logic               flush_i,
   output logic               full_o,
   output logic               empty_o,
   output logic [ENTRY_W-1:0] headData_o
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]   fillLevel;
   logic               popAccept;
   logic               pushAccept;

   assign fillLevel  = wrPtr_q - rdPtr_q;
   assign full_o     = (fillLevel == PTR_W'(FIFO_DEPTH));
   assign empty_o    = (fillLevel == '0);
   assign headData_o = mem_q[rdPtr_q[ADDR_W-1:0]];

   // A flush frees the whole FIFO, so it also makes room for a push when full.
   assign popAccept  = pop_i && !empty_o && !flush_i;
   assign pushAccept = push_i && (!full_o || popAccept || flush_i);

   // Pointer next-state: flush jumps the read pointer onto the write pointer.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      if (flush_i) begin
         rdPtr_d = wrPtr_q;
      end else if (popAccept) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (pushAccept) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
      end
   end

   // Storage array; contents need no reset because the pointers gate them.
   always_ff @(posedge clk) begin
      if (pushAccept) begin
         mem_q[wrPtr_q[ADDR_W-1:0]] <= pushData_i;
      end
   end

endmodule

// File: rtl/display_buffer_arbiter.sv
// Owns the single write port of the character display buffer. CPU writes
// are queued in a FIFO and drained one per cycle while idle; a clear request
// sweeps every screen cell with the blank character and discards any queued
// writes it would overwrite anyway. All outputs come straight from registers.
module display_buffer_arbiter #(
   parameter int                             POSITIONS  = display_pkg::SCREEN_POSITIONS,
   parameter int                             FIFO_DEPTH = display_pkg::DEFAULT_FIFO_DEPTH,
   parameter logic [display_pkg::CHAR_W-1:0] BLANK_CODE = display_pkg::BLANK_CODE
) (
   input logic                     clk,
   input logic                     reset,
   display_buffer_arbiter_if.slave bus
);
   import display_pkg::*;

   localparam logic [POSITION_W-1:0] LAST_POS  = POSITION_W'(POSITIONS - 1);
   localparam logic [POSITION_W:0]   POS_LIMIT = (POSITION_W + 1)'(POSITIONS);

   arb_state_t            state_q, state_d;
   logic [POSITION_W-1:0] clearCount_q, clearCount_d;
   logic                  busy_q, busy_d;
   logic                  overflow_q, overflow_d;
   logic                  bufWriteEnable_q, bufWriteEnable_d;
   logic [POSITION_W-1:0] bufPosition_q, bufPosition_d;
   logic [CHAR_W-1:0]     bufCharCode_q, bufCharCode_d;

   logic                  positionValid;
   logic                  fifoPush;
   logic                  fifoPop;
   logic                  fifoFlush;
   logic                  fifoFull;
   logic                  fifoEmpty;
   logic                  pushDropped;
   logic [ENTRY_W-1:0]    fifoHead;
   fifo_entry_t           headEntry;
   fifo_entry_t           newEntry;

   assign positionValid = ({1'b0, bus.cpu_position} < POS_LIMIT);
   assign fifoPush      = bus.cpu_write_enable && positionValid;
   assign fifoFlush     = bus.clear_request;
   assign fifoPop       = (state_q == ST_IDLE) && !fifoEmpty && !bus.clear_request;
   assign pushDropped   = fifoPush && fifoFull && !fifoPop && !fifoFlush;
   assign newEntry      = makeEntry(bus.cpu_position, bus.cpu_char_code);
   assign headEntry     = fifo_entry_t'(fifoHead);

   display_write_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .ENTRY_W    (ENTRY_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (fifoPush),
      .pushData_i (newEntry),
      .pop_i      (fifoPop),
      .flush_i    (fifoFlush),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty),
      .headData_o (fifoHead)
   );

   // Next-state and next-output logic: drain the FIFO when idle, sweep blanks when clearing.
   always_comb begin
      state_d          = state_q;
      clearCount_d     = clearCount_q;
      busy_d           = 1'b0;
      overflow_d       = overflow_q | pushDropped;
      bufWriteEnable_d = 1'b0;
      bufPosition_d    = '0;
      bufCharCode_d    = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.clear_request) begin
               state_d      = ST_CLEAR;
               clearCount_d = '0;
               busy_d       = 1'b1;
            end else if (!fifoEmpty) begin
               bufWriteEnable_d = 1'b1;
               bufPosition_d    = headEntry.position;
               bufCharCode_d    = headEntry.charCode;
            end
         end
         ST_CLEAR: begin
            bufWriteEnable_d = 1'b1;
            bufPosition_d    = clearCount_q;
            bufCharCode_d    = BLANK_CODE;
            busy_d           = 1'b1;
            if (bus.clear_request) begin
               clearCount_d = '0;
            end else if (clearCount_q == LAST_POS) begin
               state_d      = ST_IDLE;
               clearCount_d = '0;
               busy_d       = 1'b0;
            end else begin
               clearCount_d = clearCount_q + POSITION_W'(1);
            end
         end
         default: begin
            state_d      = ST_IDLE;
            clearCount_d = '0;
         end
      endcase
   end

   // State, clear counter, sticky overflow and registered buffer-port outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         clearCount_q     <= '0;
         busy_q           <= 1'b0;
         overflow_q       <= 1'b0;
         bufWriteEnable_q <= 1'b0;
         bufPosition_q    <= '0;
         bufCharCode_q    <= '0;
      end else begin
         state_q          <= state_d;
         clearCount_q     <= clearCount_d;
         busy_q           <= busy_d;
         overflow_q       <= overflow_d;
         bufWriteEnable_q <= bufWriteEnable_d;
         bufPosition_q    <= bufPosition_d;
         bufCharCode_q    <= bufCharCode_d;
      end
   end

   assign bus.busy                = busy_q;
   assign bus.overflow            = overflow_q;
   assign bus.buffer_write_enable = bufWriteEnable_q;
   assign bus.buffer_position     = bufPosition_q;
   assign bus.buffer_char_code    = bufCharCode_q;

endmodule
